// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - Shared encodings and alignment helpers for the data-memory access controller
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ST_RD = 3'd2,
      ST_WR = 3'd3,
      RESP  = 3'd4
   } state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      if (size == SZ_HALF) mis = lane[0];
      if (size == SZ_WORD) mis = |lane;
      return mis;
   endfunction

   // Drops the low address bits a half or word access cannot address
   function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
      logic [1:0] al;
      al = lane;
      if (size == SZ_HALF) al[0] = 1'b0;
      if (size == SZ_WORD) al = 2'b00;
      return al;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - Core request/response and word-memory port bundle with controller/initiator views
interface mem_access_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              Req;
   logic              Ready;
   logic              Op;
   logic [1:0]        Size;
   logic              Unsigned;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] StoreData;
   logic              Done;
   logic [DATA_W-1:0] LoadData;
   logic              Err;
   logic [ADDR_W-1:0] MemAddress;
   logic [DATA_W-1:0] MemWriteData;
   logic              MemWrite;
   logic              MemRead;
   logic [DATA_W-1:0] MemReadData;

   modport slave (
      input  Req, Op, Size, Unsigned, Addr, StoreData, MemReadData,
      output Ready, Done, LoadData, Err, MemAddress, MemWriteData, MemWrite, MemRead
   );

   modport master (
      output Req, Op, Size, Unsigned, Addr, StoreData, MemReadData,
      input  Ready, Done, LoadData, Err, MemAddress, MemWriteData, MemWrite, MemRead
   );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - Combinational byte-lane extract (loads) and merge (sub-word stores), little-endian
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  size_e             size_i,
   input  logic [1:0]        lane_i,
   input  logic              uns_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic [DATA_W-1:0] store_i,
   output logic [DATA_W-1:0] load_o,
   output logic [DATA_W-1:0] merged_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        sign_v;

   always_comb begin
      byte_v   = word_i[8*lane_i +: 8];
      half_v   = lane_i[1] ? word_i[31:16] : word_i[15:0];
      sign_v   = 1'b0;
      load_o   = word_i;
      merged_o = store_i;
      case (size_i)
         SZ_BYTE: begin
            sign_v   = ~uns_i & byte_v[7];
            load_o   = {{(DATA_W-8){sign_v}}, byte_v};
            merged_o = word_i;
            merged_o[8*lane_i +: 8] = store_i[7:0];
         end
         SZ_HALF: begin
            sign_v   = ~uns_i & half_v[15];
            load_o   = {{(DATA_W-16){sign_v}}, half_v};
            merged_o = word_i;
            merged_o[16*lane_i[1] +: 16] = store_i[15:0];
         end
         default: begin
            load_o   = word_i;
            merged_o = store_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - One-at-a-time load/store initiator onto a word-only memory, byte/half via read-modify-write
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word report Err instead of being forced aligned.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic               Clock,
   input  logic               Reset_n,
   mem_access_ctrl_if.slave   bus
);

   state_e            state_q, state_d;
   size_e             size_q;
   logic [1:0]        lane_q;
   logic              uns_q;
   logic [DATA_W-1:0] sdata_q;
   logic              err_q;
   logic [DATA_W-1:0] load_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] maddr_q;

   logic              accept;
   logic              req_err;
   logic [1:0]        lane_acc;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merged;

   always_comb begin
      accept = (state_q == IDLE) && bus.Req;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      req_err  = (bus.Size == SZ_RSVD) || is_misaligned(bus.Size, bus.Addr[1:0]);
      lane_acc = bus.Addr[1:0];
`else
      req_err  = (bus.Size == SZ_RSVD);
      lane_acc = align_lane(bus.Size, bus.Addr[1:0]);
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err)                  state_d = RESP;
               else if (bus.Op == OP_LOAD)   state_d = LOAD;
               else if (bus.Size == SZ_WORD) state_d = ST_WR;
               else                          state_d = ST_RD;
            end
         end
         LOAD:    state_d = RESP;
         ST_RD:   state_d = ST_WR;
         ST_WR:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         size_q  <= SZ_BYTE;
         lane_q  <= 2'b00;
         uns_q   <= 1'b0;
         sdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         size_q  <= size_e'(bus.Size);
         lane_q  <= lane_acc;
         uns_q   <= bus.Unsigned;
         sdata_q <= bus.StoreData;
         err_q   <= req_err;
      end
   end

   // Memory-side registers only move when a real memory access follows, so they hold across errors
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         maddr_q <= '0;
         wdata_q <= '0;
         load_q  <= '0;
      end else begin
         if (accept && !req_err)
            maddr_q <= {bus.Addr[ADDR_W-1:2], 2'b00};
         if (accept && !req_err && bus.Op == OP_STORE && bus.Size == SZ_WORD)
            wdata_q <= bus.StoreData;
         else if (state_q == ST_RD)
            wdata_q <= merged;
         if (state_q == LOAD)
            load_q <= load_ext;
      end
   end

   mem_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .size_i   (size_q),
      .lane_i   (lane_q),
      .uns_i    (uns_q),
      .word_i   (bus.MemReadData),
      .store_i  (sdata_q),
      .load_o   (load_ext),
      .merged_o (merged)
   );

   // Strobes decode straight from state so an async reset drops them immediately
   assign bus.Ready        = (state_q == IDLE);
   assign bus.Done         = (state_q == RESP);
   assign bus.Err          = err_q;
   assign bus.LoadData     = load_q;
   assign bus.MemAddress   = maddr_q;
   assign bus.MemWriteData = wdata_q;
   assign bus.MemWrite     = (state_q == ST_WR);
   assign bus.MemRead      = (state_q == LOAD) || (state_q == ST_RD);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - Self-checking bench: vector table, corner sequences, randomized run vs reference model
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic Clock;
   logic Reset_n;
   int   checks;
   int   failures;

   mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   mem_access_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Behavioural word memory: combinational read, posedge write, poison value when not reading
   logic [31:0] mem [0:63];
   logic        pl_we;
   logic [5:0]  pl_idx;
   logic [31:0] pl_val;

   always @(posedge Clock) begin
      if (pl_we) mem[pl_idx] <= pl_val;
      else if (bus.MemWrite) mem[bus.MemAddress[7:2]] <= bus.MemWriteData;
   end
   assign bus.MemReadData = bus.MemRead ? mem[bus.MemAddress[7:2]] : 32'hDEAD0BAD;

   logic [31:0] ref_mem [0:63];
   logic [31:0] ref_held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] v);
      @(negedge Clock);
      pl_we = 1'b1; pl_idx = a[7:2]; pl_val = v;
      @(posedge Clock);
      #1 pl_we = 1'b0;
   endtask

   task automatic do_req(input logic op, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int rds, output int wrs,
                         output logic [31:0] ld, output logic er);
      int w;
      @(negedge Clock);
      bus.Req = 1'b1; bus.Op = op; bus.Size = sz; bus.Unsigned = un;
      bus.Addr = a; bus.StoreData = d;
      w = 0;
      while (!bus.Ready && w < 20) begin
         @(negedge Clock);
         w++;
      end
      if (!bus.Ready) chk("ready_timeout", 32'(bus.Ready), 32'd1);
      @(posedge Clock);
      #1 bus.Req = 1'b0;
      lat = 0; rds = 0; wrs = 0;
      do begin
         @(negedge Clock);
         lat++;
         if (bus.MemRead)  rds++;
         if (bus.MemWrite) wrs++;
      end while (!bus.Done && lat < 10);
      ld = bus.LoadData;
      er = bus.Err;
      @(negedge Clock);
      chk("done_one_cycle", 32'(bus.Done), 32'd0);
   endtask

   task automatic model(input logic op, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int rds, output int wrs, output logic er);
      int nbytes, sh;
      logic [31:0] aa, w, mask, v;
      er = (sz == 2'd3) || (TRAP && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)));
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      aa = a;
      aa = aa & ~32'(nbytes - 1);
      sh = 8 * int'(aa[1:0]);
      mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
      w = ref_mem[aa[7:2]];
      rds = 0; wrs = 0;
      if (er) begin
         lat = 1;
      end else if (op == 1'b0) begin
         lat = 2; rds = 1;
         v = (w >> sh) & mask;
         if (!un && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
         ref_held = v;
      end else begin
         lat = (nbytes == 4) ? 2 : 3;
         rds = (nbytes == 4) ? 0 : 1;
         wrs = 1;
         ref_mem[aa[7:2]] = (w & ~(mask << sh)) | ((d & mask) << sh);
      end
   endtask

   typedef struct {
      logic        op;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_ld;
      logic        exp_er;
      int          exp_lat;
      logic [31:0] chk_a;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int lat, rds, wrs, er_i;
      logic [31:0] ld, held9;
      logic er;
      checks = 0; failures = 0;
      pl_we = 1'b0; pl_idx = '0; pl_val = '0;
      bus.Req = 1'b0; bus.Op = 1'b0; bus.Size = 2'd0; bus.Unsigned = 1'b0;
      bus.Addr = '0; bus.StoreData = '0;
      Reset_n = 1'b0;

      #12;
      chk("rst_ready",   32'(bus.Ready), 32'd1);
      chk("rst_done",    32'(bus.Done), 32'd0);
      chk("rst_err",     32'(bus.Err), 32'd0);
      chk("rst_memwr",   32'(bus.MemWrite), 32'd0);
      chk("rst_memrd",   32'(bus.MemRead), 32'd0);
      chk("rst_loaddata", bus.LoadData, 32'd0);
      chk("rst_memaddr", bus.MemAddress, 32'd0);
      chk("rst_memwdata", bus.MemWriteData, 32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;

      // Directed vector table
      held9 = TRAP ? 32'h00008000 : 32'hDEADBEEF;
      tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'h10, 32'hDEADBEEF};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'h10, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 32'hDEADBEEF, 1'b0, 3, 32'h20, 32'h1122AA44};
      tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h30, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 32'h30, 32'h8000F0FF};
      tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h30, 32'h0,        32'h000000FF, 1'b0, 2, 32'h30, 32'h8000F0FF};
      tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h32, 32'h0,        32'hFFFF8000, 1'b0, 2, 32'h30, 32'h8000F0FF};
      tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h32, 32'h0,        32'h00008000, 1'b0, 2, 32'h30, 32'h8000F0FF};
      if (TRAP)
         tbl[7] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h00008000, 1'b1, 1, 32'h10, 32'hDEADBEEF};
      else
         tbl[7] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'h10, 32'hDEADBEEF};
      tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h30, 32'h0,        held9,        1'b1, 1, 32'h30, 32'h8000F0FF};
      tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, held9,        1'b0, 3, 32'h20, 32'hBEEFAA44};
      tbl[10] = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        32'h000000BE, 1'b0, 2, 32'h20, 32'hBEEFAA44};

      preload(8'h20, 32'h11223344);
      preload(8'h30, 32'h8000F0FF);
      for (int i = 0; i < 11; i++) begin
         do_req(tbl[i].op, tbl[i].sz, tbl[i].un, tbl[i].a, tbl[i].d, lat, rds, wrs, ld, er);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
         chk($sformatf("vec%0d_loaddata", i), ld, tbl[i].exp_ld);
         chk($sformatf("vec%0d_mem", i), mem[tbl[i].chk_a[7:2]], tbl[i].exp_mem);
         chk($sformatf("vec%0d_memread_cycles", i), 32'(rds),
             32'(!tbl[i].exp_er && (tbl[i].op == 1'b0 || tbl[i].sz != 2'd2)));
         chk($sformatf("vec%0d_memwrite_cycles", i), 32'(wrs), 32'(!tbl[i].exp_er && tbl[i].op));
      end

      // Reset in the middle of a sub-word store's write cycle
      begin
         int w;
         preload(8'h40, 32'h55555555);
         @(negedge Clock);
         bus.Req = 1'b1; bus.Op = 1'b1; bus.Size = 2'd0; bus.Unsigned = 1'b0;
         bus.Addr = 32'h40; bus.StoreData = 32'hAA;
         @(posedge Clock);
         #1 bus.Req = 1'b0;
         w = 0;
         do begin
            @(negedge Clock);
            w++;
         end while (!bus.MemWrite && w < 10);
         chk("rst_mid_reach_st_wr", 32'(bus.MemWrite), 32'd1);
         Reset_n = 1'b0;
         #1;
         chk("rst_mid_memwrite", 32'(bus.MemWrite), 32'd0);
         chk("rst_mid_ready", 32'(bus.Ready), 32'd1);
         @(posedge Clock);
         @(negedge Clock);
         Reset_n = 1'b1;
         chk("rst_mid_mem_untouched", mem[6'h10], 32'h55555555);
         chk("rst_mid_loaddata", bus.LoadData, 32'd0);
      end

      // Req held high across back-to-back alternating word store/load
      begin
         int q[$];
         int idx, done_cnt, cyc, cur;
         logic prev_done;
         logic [31:0] dat [8];
         for (int i = 0; i < 8; i++) dat[i] = $urandom;
         idx = 0; done_cnt = 0; cyc = 0; prev_done = 1'b0;
         @(negedge Clock);
         bus.Req = 1'b1; bus.Op = 1'b1; bus.Size = 2'd2; bus.Addr = 32'h80; bus.StoreData = dat[0];
         while (done_cnt < 8 && cyc < 200) begin
            if (bus.Done) begin
               done_cnt++;
               if (prev_done) chk("b2b_done_pulse_width", 32'd2, 32'd1);
               cur = (q.size() > 0) ? q.pop_front() : -1;
               if (cur >= 0 && cur % 2 == 1)
                  chk($sformatf("b2b_load%0d", cur), bus.LoadData, dat[cur / 2]);
            end
            if (bus.Ready && bus.Done) chk("b2b_ready_during_done", 32'd1, 32'd0);
            prev_done = bus.Done;
            if (bus.Ready && idx < 8) begin
               q.push_back(idx);
               @(posedge Clock);
               #1;
               idx++;
               if (idx < 8) begin
                  bus.Op = (idx % 2 == 0);
                  bus.Addr = 32'h80 + 32'(4 * (idx / 2));
                  bus.StoreData = dat[idx / 2];
               end else begin
                  bus.Req = 1'b0;
               end
            end
            @(negedge Clock);
            cyc++;
         end
         bus.Req = 1'b0;
         chk("b2b_done_count", 32'(done_cnt), 32'd8);
         chk("b2b_accept_count", 32'(idx), 32'd8);
         @(negedge Clock);
         chk("b2b_no_extra_done", 32'(bus.Done), 32'd0);
         ref_held = dat[3];
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 64; i++) begin
         logic [31:0] v;
         v = $urandom;
         ref_mem[i] = v;
         preload(8'(4 * i), v);
      end
      for (int i = 0; i < 150; i++) begin
         logic op, un;
         logic [1:0] sz;
         logic [31:0] a, d;
         int elat, erds, ewrs;
         logic eer;
         op = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         un = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 255));
         d  = $urandom;
         do_req(op, sz, un, a, d, lat, rds, wrs, ld, er);
         model(op, sz, un, a, d, elat, erds, ewrs, eer);
         er_i = int'(er);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
         chk($sformatf("rnd%0d_err", i), 32'(er_i), 32'(eer));
         chk($sformatf("rnd%0d_loaddata", i), ld, ref_held);
         chk($sformatf("rnd%0d_memread_cycles", i), 32'(rds), 32'(erds));
         chk($sformatf("rnd%0d_memwrite_cycles", i), 32'(wrs), 32'(ewrs));
         chk($sformatf("rnd%0d_mem", i), mem[a[7:2]], ref_mem[a[7:2]]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
